// File: rtl/lsu_mem_arbiter_if.sv
// Bus bundle between the two LSU slots, the memory ports and the arbiter.
//   req_valid/req_ready/req_we : per-slot handshake and store/load select (bit i = LSUi)
//   req_addr0/1, req_wdata0/1  : byte address and store data per slot
//   resp_valid/resp_err        : per-slot load-valid and out-of-range flags
//   resp_data                  : shared load data, qualified by resp_valid
//   mem_wr_* / mem_rd_*        : memory write port and registered read port
//   mem_data_in                : memory read data (one cycle after mem_rd_en)
//   conflict_cnt               : saturating count of cycles with a refused request
// master = requesters plus memory model side, slave = arbiter side.
interface lsu_mem_arbiter_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_we;
    logic [31:0] req_addr0;
    logic [31:0] req_addr1;
    logic [31:0] req_wdata0;
    logic [31:0] req_wdata1;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_err;
    logic [31:0] resp_data;
    logic        mem_wr_en;
    logic [31:0] mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic        mem_rd_en;
    logic [31:0] mem_rd_addr;
    logic [31:0] mem_data_in;
    logic [15:0] conflict_cnt;

    modport master (
        output req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1, mem_data_in,
        input  req_ready, resp_valid, resp_err, resp_data,
        input  mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_en, mem_rd_addr, conflict_cnt
    );

    modport slave (
        input  req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1, mem_data_in,
        output req_ready, resp_valid, resp_err, resp_data,
        output mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_en, mem_rd_addr, conflict_cnt
    );
endinterface

// File: rtl/lsu_mem_arbiter.sv
// Arbiter sharing main memory (one write port, one 1-cycle registered read port)
// between the two VLIW load/store slots. One load and one store can be granted
// together; any other pair of requests is serialised with a round-robin pointer.
// Ports:
//   clk : clock
//   rst : synchronous active-low reset
//   bus : lsu_mem_arbiter_if.slave (request handshake, responses, memory ports,
//         conflict counter)
module lsu_mem_arbiter #(
    parameter int unsigned MEM_WORDS   = 36,
    parameter int unsigned INIT_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    lsu_mem_arbiter_if.slave bus
);
    localparam logic [31:0]      ADDR_LIMIT = 32'(4 * MEM_WORDS);
    localparam int unsigned      CNT_W      = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] INIT_LAST  = CNT_W'(INIT_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] init_cnt_r;
    logic             rr_ptr_r;
    logic [15:0]      conflict_cnt_r;
    logic [1:0]       resp_valid_r;
    logic [1:0]       resp_err_r;
    logic             rd_mem_r;

    logic [1:0]       grant_s;
    logic             refused_s;
    logic [1:0]       in_range_s;
    logic             same_word_s;
    logic             load_slot_s;
    logic [1:0]       wr_go_s;
    logic [1:0]       rd_go_s;
    logic             mem_wr_en_s;
    logic [31:0]      mem_wr_addr_s;
    logic [31:0]      mem_wr_data_s;
    logic             mem_rd_en_s;
    logic [31:0]      mem_rd_addr_s;

    assign in_range_s[0] = (bus.req_addr0 < ADDR_LIMIT);
    assign in_range_s[1] = (bus.req_addr1 < ADDR_LIMIT);
    assign same_word_s   = (bus.req_addr0[31:2] == bus.req_addr1[31:2]);
    // Only meaningful when the two slots differ in type: the load is slot 1 iff slot 0 stores.
    assign load_slot_s   = bus.req_we[0];

    // Out-of-range accesses are accepted but never reach the memory.
    assign wr_go_s = grant_s &  bus.req_we & in_range_s;
    assign rd_go_s = grant_s & ~bus.req_we & in_range_s;

    // Next-state and grant decision.
    always_comb begin
        state_nxt_s = state_r;
        grant_s     = 2'b00;
        refused_s   = 1'b0;
        case (state_r)
            ST_INIT: begin
                if (init_cnt_r == INIT_LAST) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_INIT;
                end
            end
            ST_RUN: begin
                case (bus.req_valid)
                    2'b01: grant_s = 2'b01;
                    2'b10: grant_s = 2'b10;
                    2'b11: begin
                        if (bus.req_we[0] == bus.req_we[1]) begin
                            grant_s   = rr_ptr_r ? 2'b10 : 2'b01;
                            refused_s = 1'b1;
                        end else if (!same_word_s || (rr_ptr_r == load_slot_s)) begin
                            // Same-word pair with the pointer on the load: the registered
                            // read returns the pre-store word, so load-before-store holds.
                            grant_s = 2'b11;
                        end else begin
                            // Store goes first; req_we is exactly the store slot's mask.
                            grant_s   = bus.req_we;
                            refused_s = 1'b1;
                        end
                    end
                    default: grant_s = 2'b00;
                endcase
            end
            default: state_nxt_s = ST_INIT;
        endcase
    end

    // Memory port drive from the granted requester; zero when idle.
    always_comb begin
        mem_wr_en_s   = 1'b0;
        mem_wr_addr_s = 32'h0000_0000;
        mem_wr_data_s = 32'h0000_0000;
        mem_rd_en_s   = 1'b0;
        mem_rd_addr_s = 32'h0000_0000;
        if (wr_go_s[0]) begin
            mem_wr_en_s   = 1'b1;
            mem_wr_addr_s = bus.req_addr0;
            mem_wr_data_s = bus.req_wdata0;
        end else if (wr_go_s[1]) begin
            mem_wr_en_s   = 1'b1;
            mem_wr_addr_s = bus.req_addr1;
            mem_wr_data_s = bus.req_wdata1;
        end else begin
            mem_wr_en_s   = 1'b0;
        end
        if (rd_go_s[0]) begin
            mem_rd_en_s   = 1'b1;
            mem_rd_addr_s = bus.req_addr0;
        end else if (rd_go_s[1]) begin
            mem_rd_en_s   = 1'b1;
            mem_rd_addr_s = bus.req_addr1;
        end else begin
            mem_rd_en_s   = 1'b0;
        end
    end

    // State, init counter, round-robin pointer, conflict counter and response flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r        <= ST_INIT;
            init_cnt_r     <= {CNT_W{1'b0}};
            rr_ptr_r       <= 1'b0;
            conflict_cnt_r <= 16'h0000;
            resp_valid_r   <= 2'b00;
            resp_err_r     <= 2'b00;
            rd_mem_r       <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if ((state_r == ST_INIT) && (init_cnt_r != INIT_LAST)) begin
                init_cnt_r <= init_cnt_r + CNT_W'(1);
            end
            if (refused_s) begin
                rr_ptr_r <= ~rr_ptr_r;
                if (conflict_cnt_r != 16'hFFFF) begin
                    conflict_cnt_r <= conflict_cnt_r + 16'h0001;
                end
            end
            resp_valid_r <= grant_s & ~bus.req_we;
            resp_err_r   <= grant_s & ~in_range_s;
            rd_mem_r     <= |rd_go_s;
        end
    end

    assign bus.req_ready    = grant_s;
    assign bus.mem_wr_en    = mem_wr_en_s;
    assign bus.mem_wr_addr  = mem_wr_addr_s;
    assign bus.mem_wr_data  = mem_wr_data_s;
    assign bus.mem_rd_en    = mem_rd_en_s;
    assign bus.mem_rd_addr  = mem_rd_addr_s;
    assign bus.resp_valid   = resp_valid_r;
    assign bus.resp_err     = resp_err_r;
    // Out-of-range loads have no memory read behind them and return zero.
    assign bus.resp_data    = rd_mem_r ? bus.mem_data_in : 32'h0000_0000;
    assign bus.conflict_cnt = conflict_cnt_r;
endmodule

// File: tb/tb_lsu_mem_arbiter.sv
module tb_lsu_mem_arbiter;
    localparam int MEM_WORDS = 36;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    lsu_mem_arbiter_if bus ();

    lsu_mem_arbiter #(.MEM_WORDS(MEM_WORDS), .INIT_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        longint      due;
        logic [1:0]  v;
        logic [1:0]  e;
        logic [31:0] d;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          compared   = 0;
    int          mismatched = 0;
    longint      cyc        = 0;
    logic [31:0] mem_array [MEM_WORDS];
    logic [31:0] ref_mem   [MEM_WORDS];

    function automatic logic [31:0] init_word(input int i);
        return 32'hA5A5_0000 | 32'(i);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: image reloaded during reset, registered read (old data on same-cycle write).
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < MEM_WORDS; i++) mem_array[i] <= init_word(i);
        end else if (bus.mem_wr_en && (bus.mem_wr_addr < 32'(4 * MEM_WORDS))) begin
            mem_array[bus.mem_wr_addr[7:2]] <= bus.mem_wr_data;
        end
        if (bus.mem_rd_en) begin
            if (bus.mem_rd_addr < 32'(4 * MEM_WORDS)) bus.mem_data_in <= mem_array[bus.mem_rd_addr[7:2]];
            else                                      bus.mem_data_in <= 32'hBAD0_BAD0;
        end
    end

    // Response monitor: pops the expectation due this cycle, flags anything unexpected.
    always @(negedge clk) begin
        if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            mon_e = sb_q.pop_front();
            compared++;
            if ({bus.resp_valid, bus.resp_err, bus.resp_data} !== {mon_e.v, mon_e.e, mon_e.d}) begin
                mismatched++;
                $display("FAIL resp @%0d: got valid=%b err=%b data=%h, want valid=%b err=%b data=%h",
                         cyc, bus.resp_valid, bus.resp_err, bus.resp_data, mon_e.v, mon_e.e, mon_e.d);
            end
        end else if ((bus.resp_valid | bus.resp_err) !== 2'b00) begin
            compared++;
            mismatched++;
            $display("FAIL resp_unexpected @%0d: got valid=%b err=%b, want none",
                     cyc, bus.resp_valid, bus.resp_err);
        end
    end

    task automatic set_req(input logic [1:0] v, input logic [1:0] we, input logic [31:0] a0,
                           input logic [31:0] a1, input logic [31:0] d0, input logic [31:0] d1);
        bus.req_valid  = v;
        bus.req_we     = we;
        bus.req_addr0  = a0;
        bus.req_addr1  = a1;
        bus.req_wdata0 = d0;
        bus.req_wdata1 = d1;
    endtask

    task automatic idle;
        set_req(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic push_exp(input logic [1:0] v, input logic [1:0] e, input logic [31:0] d);
        exp_t x;
        x.due = cyc + 1;
        x.v   = v;
        x.e   = e;
        x.d   = d;
        sb_q.push_back(x);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // {req_ready, mem_wr_en, mem_rd_en, mem_wr_addr, mem_wr_data, mem_rd_addr}
    function automatic logic [99:0] bus_obs();
        return {bus.req_ready, bus.mem_wr_en, bus.mem_rd_en, bus.mem_wr_addr, bus.mem_wr_data, bus.mem_rd_addr};
    endfunction

    task automatic test_reset;
        logic [151:0] all_out;
        rst = 1'b0;
        set_req(2'b11, 2'b00, 32'h0, 32'h4, 32'h0, 32'h0);
        @(negedge clk);
        all_out = {bus.req_ready, bus.resp_valid, bus.resp_err, bus.mem_wr_en, bus.mem_rd_en, bus.conflict_cnt,
                   bus.resp_data, bus.mem_wr_addr, bus.mem_wr_data, bus.mem_rd_addr};
        compared++;
        if (all_out !== {152{1'b0}}) begin
            mismatched++;
            $display("FAIL reset_outputs: got %h, want all zero", all_out);
        end
        step;
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            compared++;
            if ({bus.req_ready, bus.mem_wr_en, bus.mem_rd_en, bus.conflict_cnt} !== 20'h0) begin
                mismatched++;
                $display("FAIL init_cycle%0d: got ready=%b wr_en=%b rd_en=%b conflict=%0d, want all zero",
                         k, bus.req_ready, bus.mem_wr_en, bus.mem_rd_en, bus.conflict_cnt);
            end
            step;
        end
        // First RUN cycle: two loads, rr_ptr=0 -> LSU0 only.
        @(negedge clk);
        compared++;
        if (bus_obs() !== {2'b01, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0}) begin
            mismatched++;
            $display("FAIL two_loads_first: got %h, want ready=01 rd_en=1 rd_addr=0", bus_obs());
        end
        push_exp(2'b01, 2'b00, ref_mem[0]);
        step;
        set_req(2'b10, 2'b00, 32'h0, 32'h4, 32'h0, 32'h0);
        @(negedge clk);
        compared++;
        if (bus_obs() !== {2'b10, 1'b0, 1'b1, 32'h0, 32'h0, 32'h4}) begin
            mismatched++;
            $display("FAIL two_loads_second: got %h, want ready=10 rd_en=1 rd_addr=4", bus_obs());
        end
        compared++;
        if (bus.conflict_cnt !== 16'd1) begin
            mismatched++;
            $display("FAIL conflict_after_loads: got %0d want 1", bus.conflict_cnt);
        end
        push_exp(2'b10, 2'b00, ref_mem[1]);
        step;
        idle;
    endtask

    // rr_ptr=1 here; load and store to different words go together.
    task automatic test_load_store;
        set_req(2'b11, 2'b10, 32'h10, 32'h20, 32'h0, 32'hDEAD_BEEF);
        @(negedge clk);
        compared++;
        if (bus_obs() !== {2'b11, 1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF, 32'h10}) begin
            mismatched++;
            $display("FAIL load_store_pair: got %h, want ready=11 wr@20=deadbeef rd@10", bus_obs());
        end
        push_exp(2'b01, 2'b00, ref_mem[4]);
        ref_mem[8] = 32'hDEAD_BEEF;
        step;
        idle;
        step;
    endtask

    // rr_ptr=1 points at the LSU1 load: both granted, load sees the old word.
    task automatic test_same_word_rr_load;
        set_req(2'b11, 2'b01, 32'h8, 32'h8, 32'h0000_0044, 32'h0);
        @(negedge clk);
        compared++;
        if (bus_obs() !== {2'b11, 1'b1, 1'b1, 32'h8, 32'h0000_0044, 32'h8}) begin
            mismatched++;
            $display("FAIL same_word_rr_load: got %h, want ready=11 wr@8=44 rd@8", bus_obs());
        end
        push_exp(2'b10, 2'b00, ref_mem[2]);
        ref_mem[2] = 32'h0000_0044;
        step;
        idle;
        step;
    endtask

    // Two stores with rr_ptr=1: LSU1 first, then LSU0; rr_ptr ends at 0.
    task automatic test_two_stores;
        set_req(2'b11, 2'b11, 32'h30, 32'h34, 32'h1111_1111, 32'h2222_2222);
        @(negedge clk);
        compared++;
        if (bus_obs() !== {2'b10, 1'b1, 1'b0, 32'h34, 32'h2222_2222, 32'h0}) begin
            mismatched++;
            $display("FAIL two_stores_first: got %h, want ready=10 wr@34=22222222", bus_obs());
        end
        ref_mem[13] = 32'h2222_2222;
        step;
        set_req(2'b01, 2'b11, 32'h30, 32'h34, 32'h1111_1111, 32'h2222_2222);
        @(negedge clk);
        compared++;
        if (bus_obs() !== {2'b01, 1'b1, 1'b0, 32'h30, 32'h1111_1111, 32'h0}) begin
            mismatched++;
            $display("FAIL two_stores_second: got %h, want ready=01 wr@30=11111111", bus_obs());
        end
        compared++;
        if (bus.conflict_cnt !== 16'd2) begin
            mismatched++;
            $display("FAIL conflict_after_stores: got %0d want 2", bus.conflict_cnt);
        end
        ref_mem[12] = 32'h1111_1111;
        step;
        idle;
        step;
    endtask

    // rr_ptr=0 points at the LSU0 store: store only, load follows and sees new data.
    task automatic test_same_word_rr_store;
        set_req(2'b11, 2'b01, 32'h8, 32'h8, 32'h0000_0055, 32'h0);
        @(negedge clk);
        compared++;
        if (bus_obs() !== {2'b01, 1'b1, 1'b0, 32'h8, 32'h0000_0055, 32'h0}) begin
            mismatched++;
            $display("FAIL same_word_rr_store: got %h, want ready=01 wr@8=55 no read", bus_obs());
        end
        ref_mem[2] = 32'h0000_0055;
        step;
        set_req(2'b10, 2'b01, 32'h8, 32'h8, 32'h0000_0055, 32'h0);
        @(negedge clk);
        compared++;
        if (bus_obs() !== {2'b10, 1'b0, 1'b1, 32'h0, 32'h0, 32'h8}) begin
            mismatched++;
            $display("FAIL refused_load_retry: got %h, want ready=10 rd@8", bus_obs());
        end
        compared++;
        if (bus.conflict_cnt !== 16'd3) begin
            mismatched++;
            $display("FAIL conflict_after_same_word: got %0d want 3", bus.conflict_cnt);
        end
        push_exp(2'b10, 2'b00, ref_mem[2]);
        step;
        idle;
        step;
    endtask

    // Out-of-range load and store, then the last valid byte address.
    task automatic test_out_of_range;
        set_req(2'b10, 2'b00, 32'h0, 32'h90, 32'h0, 32'h0);
        @(negedge clk);
        compared++;
        if (bus_obs() !== {2'b10, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0}) begin
            mismatched++;
            $display("FAIL oor_load: got %h, want ready=10 no memory access", bus_obs());
        end
        push_exp(2'b10, 2'b10, 32'h0);
        step;
        set_req(2'b01, 2'b01, 32'h1000, 32'h0, 32'h0000_0077, 32'h0);
        @(negedge clk);
        compared++;
        if (bus_obs() !== {2'b01, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0}) begin
            mismatched++;
            $display("FAIL oor_store: got %h, want ready=01 no memory access", bus_obs());
        end
        push_exp(2'b00, 2'b01, 32'h0);
        step;
        set_req(2'b01, 2'b00, 32'h8F, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        compared++;
        if (bus_obs() !== {2'b01, 1'b0, 1'b1, 32'h0, 32'h0, 32'h8F}) begin
            mismatched++;
            $display("FAIL last_byte_load: got %h, want ready=01 rd@8f", bus_obs());
        end
        push_exp(2'b01, 2'b00, ref_mem[35]);
        step;
        idle;
        step;
    endtask

    // Consecutive single loads alternating slots; read back earlier stores.
    task automatic test_back_to_back;
        logic [31:0] addrs [6];
        logic [1:0]  mask;
        addrs = '{32'h30, 32'h34, 32'h20, 32'h08, 32'h10, 32'h8C};
        for (int i = 0; i < 6; i++) begin
            mask = (i % 2 == 0) ? 2'b01 : 2'b10;
            set_req(mask, 2'b00, addrs[i], addrs[i], 32'h0, 32'h0);
            @(negedge clk);
            compared++;
            if (bus_obs() !== {mask, 1'b0, 1'b1, 32'h0, 32'h0, addrs[i]}) begin
                mismatched++;
                $display("FAIL b2b_load%0d: got %h, want ready=%b rd@%h", i, bus_obs(), mask, addrs[i]);
            end
            push_exp(mask, 2'b00, ref_mem[int'(addrs[i][7:2])]);
            step;
        end
        idle;
        step;
    endtask

    // Reset while a load is in flight: response dropped, rr_ptr and counter cleared.
    task automatic test_reset_mid;
        set_req(2'b01, 2'b00, 32'h0C, 32'h0, 32'h0, 32'h0);
        rst = 1'b0;
        step;
        idle;
        @(negedge clk);
        compared++;
        if ({bus.resp_valid, bus.req_ready, bus.conflict_cnt} !== 20'h0) begin
            mismatched++;
            $display("FAIL reset_mid_drop: got resp_valid=%b ready=%b conflict=%0d, want all zero",
                     bus.resp_valid, bus.req_ready, bus.conflict_cnt);
        end
        step;
        rst = 1'b1;
        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = init_word(i);
        set_req(2'b11, 2'b00, 32'h0, 32'h4, 32'h0, 32'h0);
        repeat (4) step;
        @(negedge clk);
        compared++;
        if (bus_obs() !== {2'b01, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0}) begin
            mismatched++;
            $display("FAIL reset_mid_rr: got %h, want ready=01 rd@0", bus_obs());
        end
        push_exp(2'b01, 2'b00, ref_mem[0]);
        step;
        idle;
        step;
    endtask

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = init_word(i);
        idle;
        test_reset;
        test_load_store;
        test_same_word_rr_load;
        test_two_stores;
        test_same_word_rr_store;
        test_out_of_range;
        test_back_to_back;
        test_reset_mid;
        repeat (3) step;
        compared++;
        if (sb_q.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
